axi2apb_ctrl: RTL and testbench

Transaction controller of the AXI-Lite to APB bridge. It accepts one AXI-Lite read or write at a time and arbitrates between them. It runs the APB SETUP/ACCESS sequence and returns the AXI-Lite response. It consumes `SLVERR_sign` from `bridge_decoder` and returns `x_valid` to it to clear the decoder's held error flag. Unmapped addresses are answered with SLVERR and never reach APB.

---
 rtl/axi2apb_ctrl.sv | 136 +++++++++++++
 tb/tb_axi2apb_ctrl.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/axi2apb_ctrl.sv
// axi2apb_ctrl: AXI-Lite to APB transaction controller with read/write round-robin,
// decode-error bypass and APB wait-state timeout.
module axi2apb_ctrl #(
    parameter int APB_ADDR_WIDTH = 16,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT        = 16
) (
    input  logic                      ACLK,
    input  logic                      ARESETn,
    input  logic [31:0]               AWADDR,
    input  logic                      AWVALID,
    output logic                      AWREADY,
    input  logic [DATA_WIDTH-1:0]     WDATA,
    input  logic                      WVALID,
    output logic                      WREADY,
    output logic [1:0]                BRESP,
    output logic                      BVALID,
    input  logic                      BREADY,
    input  logic [31:0]               ARADDR,
    input  logic                      ARVALID,
    output logic                      ARREADY,
    output logic [DATA_WIDTH-1:0]     RDATA,
    output logic [1:0]                RRESP,
    output logic                      RVALID,
    input  logic                      RREADY,
    input  logic                      SLVERR_sign,
    output logic                      x_valid,
    output logic [APB_ADDR_WIDTH-1:0] PADDR,
    output logic [DATA_WIDTH-1:0]     PWDATA,
    output logic                      PWRITE,
    output logic                      PSEL,
    output logic                      PENABLE,
    input  logic [DATA_WIDTH-1:0]     PRDATA,
    input  logic                      PREADY,
    input  logic                      PSLVERR
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
    localparam logic [7:0] TO = 8'(TIMEOUT);

    state_t                    r_state, w_next;
    logic                      r_prefer_rd, r_pwrite;
    logic [APB_ADDR_WIDTH-1:0] r_paddr;
    logic [DATA_WIDTH-1:0]     r_pwdata, r_rdata;
    logic [1:0]                r_resp;
    logic [7:0]                r_cnt, w_cnt_inc;
    logic                      w_idle, w_wr_cand, w_grant_rd, w_grant_wr, w_accept, w_done, w_timeout;
    logic                      w_unused;

    assign w_unused   = ^{AWADDR[31:APB_ADDR_WIDTH], ARADDR[31:APB_ADDR_WIDTH]};
    // Readies are gated by reset so every output is 0 while ARESETn is low.
    assign w_idle     = (r_state == IDLE) && ARESETn;
    assign w_wr_cand  = AWVALID && WVALID;
    assign w_grant_rd = w_idle && ARVALID && (!w_wr_cand || r_prefer_rd);
    assign w_grant_wr = w_idle && w_wr_cand && (!ARVALID || !r_prefer_rd);
    assign w_accept   = w_grant_rd || w_grant_wr;
    assign w_done     = (r_state == RESP) && (r_pwrite ? BREADY : RREADY);
    assign w_cnt_inc  = (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;
    assign w_timeout  = w_cnt_inc >= TO;

    assign PADDR  = r_paddr;
    assign PWDATA = r_pwdata;
    assign PWRITE = r_pwrite;
    assign RDATA  = r_rdata;
    assign RRESP  = r_resp;
    assign BRESP  = r_resp;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) r_state <= IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        ARREADY = w_grant_rd;
        AWREADY = w_grant_wr;
        WREADY  = w_grant_wr;
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        RVALID  = 1'b0;
        BVALID  = 1'b0;
        x_valid = w_done;
        case (r_state)
            IDLE:    if (w_accept) w_next = SLVERR_sign ? RESP : SETUP;
            SETUP: begin
                PSEL   = 1'b1;
                w_next = ACCESS;
            end
            ACCESS: begin
                PSEL    = 1'b1;
                PENABLE = 1'b1;
                if (PREADY || w_timeout) w_next = RESP;
            end
            RESP: begin
                RVALID = !r_pwrite;
                BVALID = r_pwrite;
                if (w_done) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_prefer_rd <= 1'b1;
            r_pwrite    <= 1'b0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
            r_rdata     <= '0;
            r_resp      <= 2'b00;
            r_cnt       <= 8'd0;
        end else begin
            if (w_accept) begin
                r_pwrite <= w_grant_wr;
                r_paddr  <= w_grant_wr ? AWADDR[APB_ADDR_WIDTH-1:0] : ARADDR[APB_ADDR_WIDTH-1:0];
                if (w_grant_wr) r_pwdata <= WDATA;
                r_resp   <= SLVERR_sign ? 2'b10 : 2'b00;
                r_rdata  <= '0;
            end
            if (r_state == SETUP) r_cnt <= 8'd0;
            // PREADY takes priority over a coincident terminal count.
            if (r_state == ACCESS) begin
                if (PREADY) begin
                    r_resp  <= PSLVERR ? 2'b10 : 2'b00;
                    r_rdata <= r_pwrite ? '0 : PRDATA;
                end else begin
                    r_cnt <= w_cnt_inc;
                    if (w_timeout) begin
                        r_resp  <= 2'b10;
                        r_rdata <= '0;
                    end
                end
            end
            if (w_done) r_prefer_rd <= r_pwrite;
        end
    end
endmodule

// File: tb/tb_axi2apb_ctrl.sv
// tb_axi2apb_ctrl: directed self-checking bench for axi2apb_ctrl with TIMEOUT=4.
module tb_axi2apb_ctrl;
    logic        ACLK, ARESETn;
    logic [31:0] AWADDR, ARADDR, WDATA, RDATA, PWDATA, PRDATA;
    logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic        ARVALID, ARREADY, RVALID, RREADY;
    logic [1:0]  BRESP, RRESP;
    logic        SLVERR_sign, x_valid, PWRITE, PSEL, PENABLE, PREADY, PSLVERR;
    logic [15:0] PADDR;
    int checks = 0;
    int errors = 0;

    axi2apb_ctrl #(.APB_ADDR_WIDTH(16), .DATA_WIDTH(32), .TIMEOUT(4)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
        .SLVERR_sign(SLVERR_sign), .x_valid(x_valid),
        .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    initial begin
        ARESETn = 0; AWADDR = 0; ARADDR = 0; WDATA = 0; AWVALID = 0; WVALID = 0;
        BREADY = 0; ARVALID = 1; RREADY = 0; SLVERR_sign = 0; PRDATA = 0; PREADY = 0; PSLVERR = 0;
        tick(); tick();
        #1;
        check("rst_arready", 64'(ARREADY), 64'd0);
        check("rst_psel", 64'(PSEL), 64'd0);
        check("rst_rvalid", 64'(RVALID), 64'd0);
        check("rst_paddr", 64'(PADDR), 64'd0);
        ARVALID = 0;
        ARESETn = 1;
        tick();

        // zero-wait read
        ARADDR = 32'hA001_0010; ARVALID = 1; RREADY = 1; PREADY = 1; PRDATA = 32'h1234_5678;
        #1;
        check("rd_arready", 64'(ARREADY), 64'd1);
        check("rd_awready", 64'(AWREADY), 64'd0);
        tick(); ARVALID = 0; #1;
        check("rd_arready_drop", 64'(ARREADY), 64'd0);
        check("rd_setup", 64'({PSEL, PENABLE}), 64'd2);
        tick(); #1;
        check("rd_access", 64'({PSEL, PENABLE}), 64'd3);
        check("rd_paddr", 64'(PADDR), 64'h0010);
        check("rd_pwrite", 64'(PWRITE), 64'd0);
        tick(); #1;
        check("rd_rvalid", 64'(RVALID), 64'd1);
        check("rd_rdata", 64'(RDATA), 64'h1234_5678);
        check("rd_rresp", 64'(RRESP), 64'd0);
        check("rd_xvalid", 64'(x_valid), 64'd1);
        check("rd_resp_psel", 64'(PSEL), 64'd0);
        tick(); #1;
        check("rd_done", 64'({RVALID, x_valid}), 64'd0);

        // write with 3 wait states
        AWADDR = 32'hA001_0004; WDATA = 32'hDEAD_BEEF; AWVALID = 1; WVALID = 1; BREADY = 1; PREADY = 0;
        #1;
        check("wr_ready", 64'({AWREADY, WREADY, ARREADY}), 64'd6);
        tick(); AWVALID = 0; WVALID = 0; WDATA = 0; #1;
        check("wr_setup", 64'({PSEL, PENABLE}), 64'd2);
        for (int i = 0; i < 4; i++) begin
            tick(); PREADY = (i == 3); #1;
            check("wr_access", 64'({PSEL, PENABLE, PWRITE, BVALID}), 64'hE);
            check("wr_paddr", 64'(PADDR), 64'h0004);
            check("wr_pwdata", 64'(PWDATA), 64'hDEAD_BEEF);
        end
        tick(); PREADY = 0; #1;
        check("wr_bvalid", 64'({BVALID, BRESP, x_valid}), 64'b1001);
        tick();

        // decode error
        ARADDR = 32'hB000_0000; ARVALID = 1; SLVERR_sign = 1; RREADY = 0;
        #1;
        check("de_arready", 64'(ARREADY), 64'd1);
        tick(); ARVALID = 0; SLVERR_sign = 0; #1;
        check("de_resp", 64'({PSEL, RVALID, RRESP, x_valid}), 64'b01100);
        check("de_rdata", 64'(RDATA), 64'd0);
        tick(); #1;
        check("de_hold", 64'({PSEL, RVALID}), 64'b01);
        RREADY = 1; #1;
        check("de_xvalid", 64'(x_valid), 64'd1);
        tick(); #1;
        check("de_done", 64'(RVALID), 64'd0);

        // timeout read
        ARADDR = 32'hA001_0020; ARVALID = 1; PREADY = 0; PRDATA = 32'h5555_AAAA;
        tick(); ARVALID = 0; #1;
        check("to_setup", 64'({PSEL, PENABLE}), 64'd2);
        for (int i = 0; i < 4; i++) begin
            tick(); #1;
            check("to_access", 64'({PSEL, PENABLE, RVALID}), 64'b110);
        end
        tick(); #1;
        check("to_resp", 64'({PSEL, RVALID, RRESP}), 64'b0110);
        check("to_rdata", 64'(RDATA), 64'd0);
        tick();

        // write with PSLVERR
        AWADDR = 32'h0000_0008; WDATA = 32'h0BAD_F00D; AWVALID = 1; WVALID = 1; PREADY = 1; PSLVERR = 1;
        tick(); AWVALID = 0; WVALID = 0; tick(); tick(); PSLVERR = 0; #1;
        check("slv_bresp", 64'({BVALID, BRESP}), 64'b110);
        tick();

        // PREADY on the terminal-count cycle
        ARADDR = 32'hA001_0030; ARVALID = 1; PREADY = 0; PRDATA = 32'hCAFE_0001;
        tick(); ARVALID = 0;
        for (int i = 0; i < 4; i++) begin
            tick(); PREADY = (i == 3);
        end
        tick(); PREADY = 0; #1;
        check("tc_resp", 64'({RVALID, RRESP}), 64'b100);
        check("tc_rdata", 64'(RDATA), 64'hCAFE_0001);
        tick();

        // round-robin after fresh reset
        ARESETn = 0; tick(); ARESETn = 1; tick();
        ARVALID = 1; AWVALID = 1; WVALID = 1; PREADY = 1;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("rr_grant", 64'({ARREADY, AWREADY}), (k % 2 == 0) ? 64'd2 : 64'd1);
            tick();
            if (k == 3) begin ARVALID = 0; AWVALID = 0; WVALID = 0; end
            tick(); tick(); tick();
        end

        // reset during ACCESS
        ARADDR = 32'hA001_0040; ARVALID = 1; PREADY = 0;
        tick(); ARVALID = 0; tick(); #1;
        check("ra_access", 64'({PSEL, PENABLE}), 64'd3);
        ARESETn = 0; #1;
        check("ra_async", 64'({PSEL, PENABLE, RVALID}), 64'd0);
        tick(); tick(); #1;
        check("ra_no_resp", 64'({RVALID, PSEL}), 64'd0);
        ARESETn = 1; tick();
        ARVALID = 1; PREADY = 1; PRDATA = 32'h0F0F_1234;
        tick(); ARVALID = 0; tick(); tick(); #1;
        check("ra_read", 64'({RVALID, RRESP}), 64'b100);
        check("ra_rdata", 64'(RDATA), 64'h0F0F_1234);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
